// File: rtl/regfile_wb_if.sv
// Write-back bus between the two writeback sources (A: ALU, B: load unit),
// the arbiter and the register-file write port.
//   a_*/b_*        : valid/ready write request per source (addr + data)
//   RegWrite       : registered register-file write enable
//   write_address  : registered register-file write address
//   write_data     : registered register-file write data
//   pending        : one bit per register, set while a write to it is in flight
// modport master : the side that produces writes and consumes the results
// modport slave  : the arbiter
interface regfile_wb_if #(
  parameter int data_width   = 32,
  parameter int select_width = 5
);
  logic                         a_valid;
  logic                         a_ready;
  logic [select_width-1:0]      a_addr;
  logic [data_width-1:0]        a_data;
  logic                         b_valid;
  logic                         b_ready;
  logic [select_width-1:0]      b_addr;
  logic [data_width-1:0]        b_data;
  logic                         RegWrite;
  logic [select_width-1:0]      write_address;
  logic [data_width-1:0]        write_data;
  logic [2**select_width-1:0]   pending;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, RegWrite, write_address, write_data, pending
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, RegWrite, write_address, write_data, pending
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file.
// Two sources (index 0 = A, index 1 = B) each feed a 2-entry in-order FIFO.
// Every cycle at most one FIFO head is popped under round-robin arbitration
// and loaded into the registered write port (RegWrite/write_address/
// write_data). Writes to register 0 are consumed but never assert RegWrite.
// pending marks every register that still has a write queued or presented.
// Ports:
//   clk : clock, all state on posedge
//   rst : asynchronous active-high reset; flushes both FIFOs, drops RegWrite
//   wb  : regfile_wb_if slave modport (handshakes, write port, pending mask)
module regfile_wb_arbiter #(
  parameter int data_width   = 32,
  parameter int select_width = 5
) (
  input  logic          clk,
  input  logic          rst,
  regfile_wb_if.slave   wb
);

  localparam int NREG = 2**select_width;

  typedef logic [select_width-1:0] addr_t;
  typedef logic [data_width-1:0]   data_t;

  // An entry e of a 2-deep FIFO is live when the FIFO is full, or when it
  // holds one entry and e is the read slot.
  function automatic logic entry_live(input logic [1:0] cnt, input logic rd, input logic e);
    return (cnt == 2'd2) || (cnt == 2'd1 && rd == e);
  endfunction

  logic [1:0] in_valid;
  addr_t      in_addr [2];
  data_t      in_data [2];

  logic [1:0] ready;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] not_empty;

  addr_t      fifo_addr_p0 [2][2];
  data_t      fifo_data_p0 [2][2];
  logic [1:0] rd_ptr_p0;
  logic [1:0] wr_ptr_p0;
  logic [1:0] cnt_p0 [2];
  logic       last_b_p0;

  addr_t      head_addr;
  data_t      head_data;

  logic       we_p1;
  addr_t      wa_p1;
  data_t      wd_p1;

  logic [NREG-1:0] pend;

  assign in_valid   = {wb.b_valid, wb.a_valid};
  assign in_addr[0] = wb.a_addr;
  assign in_addr[1] = wb.b_addr;
  assign in_data[0] = wb.a_data;
  assign in_data[1] = wb.b_data;

  // Ready looks only at the registered count, so a full FIFO refuses a push
  // even in a cycle where it is being popped.
  always_comb begin
    ready     = '0;
    push      = '0;
    not_empty = '0;
    for (int s = 0; s < 2; s++) begin
      ready[s]     = (cnt_p0[s] != 2'd2);
      push[s]      = in_valid[s] && ready[s];
      not_empty[s] = (cnt_p0[s] != 2'd0);
    end
  end

  // Round robin: on a tie the source not granted last time wins.
  always_comb begin
    pop       = '0;
    pop[0]    = not_empty[0] && (!not_empty[1] || last_b_p0);
    pop[1]    = not_empty[1] && (!not_empty[0] || !last_b_p0);
    head_addr = pop[1] ? fifo_addr_p0[1][rd_ptr_p0[1]] : fifo_addr_p0[0][rd_ptr_p0[0]];
    head_data = pop[1] ? fifo_data_p0[1][rd_ptr_p0[1]] : fifo_data_p0[0][rd_ptr_p0[0]];
  end

  assign wb.a_ready = ready[0];
  assign wb.b_ready = ready[1];

  // ---- stage p0: FIFO control and storage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_p0 <= '0;
      wr_ptr_p0 <= '0;
      for (int s = 0; s < 2; s++) cnt_p0[s] <= 2'd0;
      last_b_p0 <= 1'b1;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_ptr_p0[s] <= ~wr_ptr_p0[s];
        if (pop[s])  rd_ptr_p0[s] <= ~rd_ptr_p0[s];
        case ({push[s], pop[s]})
          2'b10:   cnt_p0[s] <= cnt_p0[s] + 2'd1;
          2'b01:   cnt_p0[s] <= cnt_p0[s] - 2'd1;
          default: cnt_p0[s] <= cnt_p0[s];
        endcase
      end
      if (|pop) last_b_p0 <= pop[1];
    end
  end

  // Payload storage needs no reset: a zero count hides stale entries.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        fifo_addr_p0[s][wr_ptr_p0[s]] <= in_addr[s];
        fifo_data_p0[s][wr_ptr_p0[s]] <= in_data[s];
      end
    end
  end

  // ---- stage p1: registered register-file write port ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_p1 <= 1'b0;
      wa_p1 <= '0;
      wd_p1 <= '0;
    end else if (|pop) begin
      we_p1 <= (head_addr != '0);
      wa_p1 <= head_addr;
      wd_p1 <= head_data;
    end else begin
      we_p1 <= 1'b0;
    end
  end

  assign wb.RegWrite      = we_p1;
  assign wb.write_address = wa_p1;
  assign wb.write_data    = wd_p1;

  // Register 0 is never reported pending; it is cleared after the OR.
  always_comb begin
    pend = '0;
    for (int s = 0; s < 2; s++) begin
      for (int e = 0; e < 2; e++) begin
        if (entry_live(cnt_p0[s], rd_ptr_p0[s], 1'(e)))
          pend[fifo_addr_p0[s][e]] = 1'b1;
      end
    end
    if (we_p1) pend[wa_p1] = 1'b1;
    pend[0] = 1'b0;
  end

  assign wb.pending = pend;

endmodule
